sodor5_verif_core: RTL and testbench
====================================

Name: sodor5_verif_core

Overview:
- Single-cycle, ISA-level RV32I subset executor used as the golden side of the Sodor 5-stage lockstep harness.
- Each clock it consumes one instruction word from the bench and updates an architectural register file and a small data memory.
- It reports one commit record per cycle for comparison against the pipelined core.

Parameters:
- XLEN, 32, datapath and register width.
- NUM_REGS, 32, architectural registers.
- DMEM_WORDS, 16, data-memory depth in XLEN words (power of two).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- instr  in  32  instruction executed at each rising edge.
- pc  out  32  count of retired slots; +4 per non-reset edge.
- commit_valid  out  1  registered; the last edge retired a register-writing instruction.
- commit_rd  out  5  destination of that commit.
- commit_wdata  out  32  value written.
- mem_we  out  1  registered; the last edge performed a store.
- mem_addr  out  32  effective address of the last load/store.
- mem_wdata  out  32  store data, replicated into its byte lanes.
- mem_wmask  out  4  byte-lane write mask.

Behaviour:
- State arrays:
  - regfile[NUM_REGS] of XLEN.
  - dmem[DMEM_WORDS] of XLEN.
  - Both arrays have these exact hierarchical names and are writable by the bench at time 0 for preload.
  - Neither array is cleared by reset.
- x0:
  - Reads of x0 always return 0, whatever regfile[0] holds.
  - Writes to x0 are discarded; no commit record is produced for them.
- Reset:
  - reset_n low asynchronously clears pc, commit_valid, commit_rd, commit_wdata, mem_we, mem_addr, mem_wdata and mem_wmask to 0.
  - instr is ignored while reset_n is low.
  - Reset asserted mid-run loses no regfile or dmem contents.
- Timing:
  - instr is decoded combinationally and applied at the rising edge.
  - Regfile and dmem writes, and all outputs, update on that same edge.
  - The next instruction sees the result, so there are no hazards and no stalls.
- OP-IMM (opcode 0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI with sign-extended imm[11:0].
  - SLLI when funct3=1.
  - funct3=5 gives SRLI when instr[30]=0 and SRAI when instr[30]=1.
  - Shift amount is imm[4:0]; the remaining immediate bits are ignored.
- LOAD (opcode 0000011):
  - Effective address = rs1 + sext(imm).
  - Word index = addr[log2(DMEM_WORDS)+1:2], so upper bits alias (0x40 maps to word 0).
  - Byte lane = addr[1:0].
  - LB (funct3=0) sign-extends the selected byte; LBU (funct3=4) zero-extends it.
- STORE (opcode 0100011):
  - Immediate = {instr[31:25], instr[11:7]}; address formed as for loads.
  - SB (funct3=0) writes rs2[7:0] to the addressed byte lane only.
  - mem_wmask is one-hot on that lane; mem_we=1; commit_valid=0.
- Any other opcode or funct3: treated as a NOP. No regfile, dmem or commit change; mem_we=0; pc still advances.
- Output hold: when the current slot does not produce a commit or access, commit_rd/commit_wdata and mem_addr/mem_wdata/mem_wmask hold their previous values.
- Wrap-around:
  - pc wraps modulo 2^32.
  - Address arithmetic wraps modulo 2^32.

Optional Feature:
- Macro: SODOR5_WIDE_MEM_EN.
- When defined, the following are also executed:
  - LH (1), LW (2), LHU (5), SH (1), SW (2).
  - Halfword lane = addr[1]; addr[0] is ignored.
  - Word accesses ignore addr[1:0].
  - SH mask is 0011 or 1100; SW mask is 1111.
- When undefined, those encodings are NOPs as above.

Decomposition:
- Package sodor5_pkg holds:
  - opcode constants (OPC_OPIMM, OPC_LOAD, OPC_STORE);
  - funct3 constants;
  - an ALU-op enum;
  - the commit-record struct.
- One natural sub-module: sodor5_alu, the combinational OP-IMM ALU (op, a, imm → result). Decode, address generation and memories stay in the top module.

Test Plan:
- Preload x1=0x00000008 and dmem[i]=i×0x11111111. Apply LB x2,1(x1) → commit rd=2, wdata=0x00000022.
- Preload x1=0x0000003C. LBU x3,3(x1) → 0x000000FF. Then LB x4,3(x1) → 0xFFFFFFFF.
- Preload x5=0x14, x6=0x000000AB. SB x6,1(x5) → mem_we=1, mask=0010, dmem[5]=0x5555AB55. A following LBU from the same address returns 0xAB.
- Preload x7=0x80000000. SRAI x8,x7,4 → 0xF8000000. SRLI → 0x08000000. ADDI x0,x7,1 → no commit. ADDI x9,x0,-1 → 0xFFFFFFFF with regfile[0] preloaded to 0x1234.
- Wrap: x1=0x40, LBU x2,0(x1) → reads dmem[0] byte 0 → 0x00000000. Opcode 0x7F → NOP, pc +4.
- Assert reset_n low mid-run → all outputs 0 immediately without a clock edge; regfile/dmem unchanged after release; pc restarts at 0 and advances from the first edge after release.

Source files
------------

// File: rtl/sodor5_pkg.sv
// Shared constants, ALU op encoding and record types for the sodor5 golden executor.
package sodor5_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned DMEM_WORDS = 16;
  localparam int unsigned DMEM_AW    = $clog2(DMEM_WORDS);
  localparam int unsigned REG_AW     = 5;

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_ADDI  = 3'd0;
  localparam logic [2:0] F3_SLLI  = 3'd1;
  localparam logic [2:0] F3_SLTI  = 3'd2;
  localparam logic [2:0] F3_SLTIU = 3'd3;
  localparam logic [2:0] F3_XORI  = 3'd4;
  localparam logic [2:0] F3_SRXI  = 3'd5;
  localparam logic [2:0] F3_ORI   = 3'd6;
  localparam logic [2:0] F3_ANDI  = 3'd7;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_OR,
    ALU_AND,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA
  } alu_op_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wdata;
  } commit_t;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      wmask;
  } mem_rec_t;

endpackage

// File: rtl/sodor5_verif_core_if.sv
// Instruction/commit/memory-trace bundle between bench (master) and golden core (slave).
interface sodor5_verif_core_if;
  import sodor5_pkg::*;

  logic [XLEN-1:0]   instr;
  logic [XLEN-1:0]   pc;
  logic              commit_valid;
  logic [REG_AW-1:0] commit_rd;
  logic [XLEN-1:0]   commit_wdata;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [3:0]        mem_wmask;

  modport master (
    output instr,
    input  pc, commit_valid, commit_rd, commit_wdata,
    input  mem_we, mem_addr, mem_wdata, mem_wmask
  );

  modport slave (
    input  instr,
    output pc, commit_valid, commit_rd, commit_wdata,
    output mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/sodor5_alu.sv
// Combinational OP-IMM ALU; shifts use imm[4:0] only.
module sodor5_alu
  import sodor5_pkg::*;
(
  input  alu_op_e         i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_imm,
  output logic [XLEN-1:0] o_result_c
);

  logic [4:0] w_shamt;
  assign w_shamt = i_imm[4:0];

  always_comb begin
    o_result_c = '0;
    case (i_op)
      ALU_ADD:  o_result_c = i_a + i_imm;
      ALU_SLT:  o_result_c = XLEN'($signed(i_a) < $signed(i_imm));
      ALU_SLTU: o_result_c = XLEN'(i_a < i_imm);
      ALU_XOR:  o_result_c = i_a ^ i_imm;
      ALU_OR:   o_result_c = i_a | i_imm;
      ALU_AND:  o_result_c = i_a & i_imm;
      ALU_SLL:  o_result_c = i_a << w_shamt;
      ALU_SRL:  o_result_c = i_a >> w_shamt;
      ALU_SRA:  o_result_c = XLEN'($signed(i_a) >>> w_shamt);
      default:  o_result_c = '0;
    endcase
  end

endmodule

// File: rtl/sodor5_verif_core.sv
// Single-cycle RV32I-subset golden executor for lockstep checking.
// Define SODOR5_WIDE_MEM_EN to also execute LH/LW/LHU/SH/SW.
module sodor5_verif_core
  import sodor5_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  sodor5_verif_core_if.slave core_if
);

  // Architectural state; left uninitialised by reset so the bench can preload it.
  logic [XLEN-1:0] regfile [NUM_REGS];
  logic [XLEN-1:0] dmem    [DMEM_WORDS];

  logic [XLEN-1:0]    r_pc;
  commit_t            r_commit;
  mem_rec_t           r_mem;

  logic [6:0]         w_opcode;
  logic [REG_AW-1:0]  w_rd;
  logic [REG_AW-1:0]  w_rs1;
  logic [REG_AW-1:0]  w_rs2;
  logic [2:0]         w_f3;
  logic [XLEN-1:0]    w_rs1_val;
  logic [XLEN-1:0]    w_rs2_val;
  logic [XLEN-1:0]    w_imm_i;
  logic [XLEN-1:0]    w_imm_s;
  logic [XLEN-1:0]    w_alu_res;
  alu_op_e            w_alu_op;
  logic               w_rf_we;
  logic [XLEN-1:0]    w_rf_wdata;
  logic               w_is_load;
  logic               w_is_store;
  logic [3:0]         w_wmask;
  logic [XLEN-1:0]    w_st_data;
  logic [XLEN-1:0]    w_addr;
  logic [DMEM_AW-1:0] w_idx;
  logic [XLEN-1:0]    w_rd_word;
  logic [7:0]         w_byte;
  logic [XLEN-1:0]    w_merged;
`ifdef SODOR5_WIDE_MEM_EN
  logic [15:0]        w_half;
`endif

  assign w_opcode  = core_if.instr[6:0];
  assign w_rd      = core_if.instr[11:7];
  assign w_f3      = core_if.instr[14:12];
  assign w_rs1     = core_if.instr[19:15];
  assign w_rs2     = core_if.instr[24:20];
  assign w_imm_i   = {{20{core_if.instr[31]}}, core_if.instr[31:20]};
  assign w_imm_s   = {{20{core_if.instr[31]}}, core_if.instr[31:25], core_if.instr[11:7]};
  assign w_rs1_val = (w_rs1 == '0) ? '0 : regfile[w_rs1];
  assign w_rs2_val = (w_rs2 == '0) ? '0 : regfile[w_rs2];

  // Word index drops the byte offset; bits above the memory depth alias.
  assign w_idx     = w_addr[DMEM_AW+1:2];
  assign w_rd_word = dmem[w_idx];
  assign w_byte    = w_rd_word[{w_addr[1:0], 3'b000} +: 8];
`ifdef SODOR5_WIDE_MEM_EN
  assign w_half    = w_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];
`endif

  sodor5_alu u_alu (
    .i_op       (w_alu_op),
    .i_a        (w_rs1_val),
    .i_imm      (w_imm_i),
    .o_result_c (w_alu_res)
  );

  // Decode: unrecognised opcode/funct3 combinations fall through as NOPs.
  always_comb begin
    w_alu_op   = ALU_ADD;
    w_rf_we    = 1'b0;
    w_rf_wdata = w_alu_res;
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_wmask    = 4'b0000;
    w_st_data  = w_rs2_val;
    w_addr     = w_rs1_val + w_imm_i;
    case (w_opcode)
      OPC_OPIMM: begin
        w_rf_we = 1'b1;
        case (w_f3)
          F3_ADDI:  w_alu_op = ALU_ADD;
          F3_SLLI:  w_alu_op = ALU_SLL;
          F3_SLTI:  w_alu_op = ALU_SLT;
          F3_SLTIU: w_alu_op = ALU_SLTU;
          F3_XORI:  w_alu_op = ALU_XOR;
          F3_SRXI:  w_alu_op = core_if.instr[30] ? ALU_SRA : ALU_SRL;
          F3_ORI:   w_alu_op = ALU_OR;
          F3_ANDI:  w_alu_op = ALU_AND;
          default:  w_alu_op = ALU_ADD;
        endcase
      end
      OPC_LOAD: begin
        case (w_f3)
          F3_B: begin
            w_is_load = 1'b1; w_rf_we = 1'b1;
            w_rf_wdata = {{24{w_byte[7]}}, w_byte};
          end
          F3_BU: begin
            w_is_load = 1'b1; w_rf_we = 1'b1;
            w_rf_wdata = {24'h0, w_byte};
          end
`ifdef SODOR5_WIDE_MEM_EN
          F3_H: begin
            w_is_load = 1'b1; w_rf_we = 1'b1;
            w_rf_wdata = {{16{w_half[15]}}, w_half};
          end
          F3_HU: begin
            w_is_load = 1'b1; w_rf_we = 1'b1;
            w_rf_wdata = {16'h0, w_half};
          end
          F3_W: begin
            w_is_load = 1'b1; w_rf_we = 1'b1;
            w_rf_wdata = w_rd_word;
          end
`endif
          default: ;
        endcase
      end
      OPC_STORE: begin
        w_addr = w_rs1_val + w_imm_s;
        case (w_f3)
          F3_B: begin
            w_is_store = 1'b1;
            w_wmask    = 4'b0001 << w_addr[1:0];
            w_st_data  = {4{w_rs2_val[7:0]}};
          end
`ifdef SODOR5_WIDE_MEM_EN
          F3_H: begin
            w_is_store = 1'b1;
            w_wmask    = w_addr[1] ? 4'b1100 : 4'b0011;
            w_st_data  = {2{w_rs2_val[15:0]}};
          end
          F3_W: begin
            w_is_store = 1'b1;
            w_wmask    = 4'b1111;
          end
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
    if (w_rd == '0) w_rf_we = 1'b0;
  end

  // Byte-lane merge of store data into the addressed word.
  always_comb begin
    w_merged = w_rd_word;
    for (int b = 0; b < 4; b++) begin
      if (w_wmask[b]) w_merged[8*b +: 8] = w_st_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (w_rf_we)    regfile[w_rd] <= w_rf_wdata;
      if (w_is_store) dmem[w_idx]   <= w_merged;
    end
  end

  // Trace outputs hold their last values when the slot has no commit/access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc     <= '0;
      r_commit <= '0;
      r_mem    <= '0;
    end else begin
      r_pc         <= r_pc + XLEN'(4);
      r_commit.valid <= w_rf_we;
      if (w_rf_we) begin
        r_commit.rd    <= w_rd;
        r_commit.wdata <= w_rf_wdata;
      end
      r_mem.we <= w_is_store;
      if (w_is_load || w_is_store) r_mem.addr <= w_addr;
      if (w_is_store) begin
        r_mem.wdata <= w_st_data;
        r_mem.wmask <= w_wmask;
      end
    end
  end

  assign core_if.pc           = r_pc;
  assign core_if.commit_valid = r_commit.valid;
  assign core_if.commit_rd    = r_commit.rd;
  assign core_if.commit_wdata = r_commit.wdata;
  assign core_if.mem_we       = r_mem.we;
  assign core_if.mem_addr     = r_mem.addr;
  assign core_if.mem_wdata    = r_mem.wdata;
  assign core_if.mem_wmask    = r_mem.wmask;

endmodule

// File: tb/tb_sodor5_verif_core.sv
// Directed-vector bench for sodor5_verif_core with a queued commit/store scoreboard.
module tb_sodor5_verif_core;
  import sodor5_pkg::*;

  logic clk;
  logic reset_n;
  sodor5_verif_core_if bus ();

  sodor5_verif_core dut (
    .clk     (clk),
    .reset_n (reset_n),
    .core_if (bus.slave)
  );

  typedef struct { logic [4:0] rd; logic [31:0] data; } exp_commit_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] mask; } exp_store_t;

  exp_commit_t cq[$];
  exp_store_t  sq[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  task automatic push_commit(input logic [4:0] rd, input logic [31:0] data);
    exp_commit_t e;
    e.rd = rd; e.data = data;
    cq.push_back(e);
  endtask

  task automatic push_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    exp_store_t e;
    e.addr = addr; e.data = data; e.mask = mask;
    sq.push_back(e);
  endtask

  task automatic issue(input logic [31:0] ins);
    bus.instr = ins;
    @(posedge clk);
    #2;
    exp_pc = exp_pc + 32'd4;
  endtask

  // Monitor: consumes one expected record per presented commit/store.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.commit_valid) begin
        if (cq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_commit: got rd=%0d data=0x%08h expected none",
                   bus.commit_rd, bus.commit_wdata);
        end else begin
          exp_commit_t e;
          e = cq.pop_front();
          chk("commit_rd", 32'(bus.commit_rd), 32'(e.rd));
          chk("commit_wdata", bus.commit_wdata, e.data);
        end
      end
      if (bus.mem_we) begin
        if (sq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_store: got addr=0x%08h expected none", bus.mem_addr);
        end else begin
          exp_store_t s;
          s = sq.pop_front();
          chk("store_addr", bus.mem_addr, s.addr);
          chk("store_wdata", bus.mem_wdata, s.data);
          chk("store_wmask", 32'(bus.mem_wmask), 32'(s.mask));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pc"},    bus.pc, 32'h0);
    chk({tag, "_cv"},    32'(bus.commit_valid), 32'h0);
    chk({tag, "_crd"},   32'(bus.commit_rd), 32'h0);
    chk({tag, "_cwd"},   bus.commit_wdata, 32'h0);
    chk({tag, "_mwe"},   32'(bus.mem_we), 32'h0);
    chk({tag, "_maddr"}, bus.mem_addr, 32'h0);
    chk({tag, "_mwd"},   bus.mem_wdata, 32'h0);
    chk({tag, "_mmask"}, 32'(bus.mem_wmask), 32'h0);
  endtask

  initial begin
    bus.instr = 32'h0000007F;
    reset_n   = 1'b1;
    exp_pc    = 32'h0;
    #1 reset_n = 1'b0;
    for (int i = 0; i < 16; i++) dut.dmem[i] <= 32'(i) * 32'h11111111;
    dut.regfile[0]  <= 32'h00001234;
    dut.regfile[1]  <= 32'h00000008;
    #1;
    chk_all_zero("reset");
    @(posedge clk); #2;
    reset_n = 1'b1;
    chk("pc_after_release", bus.pc, 32'h0);

    push_commit(5'd2, 32'h00000022);
    issue(enc_i(12'd1, 5'd1, 3'd0, 5'd2, OPC_LOAD));           // LB x2,1(x1)
    chk("pc_first", bus.pc, exp_pc);

    dut.regfile[1] <= 32'h0000003C; #1;
    push_commit(5'd3, 32'h000000FF);
    issue(enc_i(12'd3, 5'd1, 3'd4, 5'd3, OPC_LOAD));           // LBU x3,3(x1)
    push_commit(5'd4, 32'hFFFFFFFF);
    issue(enc_i(12'd3, 5'd1, 3'd0, 5'd4, OPC_LOAD));           // LB x4,3(x1)

    dut.regfile[5] <= 32'h00000014;
    dut.regfile[6] <= 32'h000000AB; #1;
    push_store(32'h00000015, 32'hABABABAB, 4'b0010);
    issue(enc_s(12'd1, 5'd6, 5'd5, 3'd0));                     // SB x6,1(x5)
    chk("sb_no_commit", 32'(bus.commit_valid), 32'h0);
    chk("sb_dmem5", dut.dmem[5], 32'h5555AB55);
    push_commit(5'd10, 32'h000000AB);
    issue(enc_i(12'd1, 5'd5, 3'd4, 5'd10, OPC_LOAD));          // LBU x10,1(x5)
    chk("lbu_addr", bus.mem_addr, 32'h00000015);
    chk("lbu_no_store", 32'(bus.mem_we), 32'h0);

    dut.regfile[7] <= 32'h80000000; #1;
    push_commit(5'd8, 32'hF8000000);
    issue(enc_i(12'h404, 5'd7, 3'd5, 5'd8, OPC_OPIMM));        // SRAI x8,x7,4
    push_commit(5'd11, 32'h08000000);
    issue(enc_i(12'h004, 5'd7, 3'd5, 5'd11, OPC_OPIMM));       // SRLI x11,x7,4
    issue(enc_i(12'd1, 5'd7, 3'd0, 5'd0, OPC_OPIMM));          // ADDI x0,x7,1
    chk("x0_no_commit", 32'(bus.commit_valid), 32'h0);
    push_commit(5'd9, 32'hFFFFFFFF);
    issue(enc_i(12'hFFF, 5'd0, 3'd0, 5'd9, OPC_OPIMM));        // ADDI x9,x0,-1
    push_commit(5'd12, 32'h1);
    issue(enc_i(12'h000, 5'd7, 3'd2, 5'd12, OPC_OPIMM));       // SLTI x12,x7,0
    push_commit(5'd13, 32'h0);
    issue(enc_i(12'h001, 5'd7, 3'd3, 5'd13, OPC_OPIMM));       // SLTIU x13,x7,1
    push_commit(5'd14, 32'h54);
    issue(enc_i(12'h0FF, 5'd6, 3'd4, 5'd14, OPC_OPIMM));       // XORI
    push_commit(5'd15, 32'hFFFFFFAB);
    issue(enc_i(12'hF00, 5'd6, 3'd6, 5'd15, OPC_OPIMM));       // ORI
    push_commit(5'd16, 32'h0000000B);
    issue(enc_i(12'h00F, 5'd6, 3'd7, 5'd16, OPC_OPIMM));       // ANDI
    push_commit(5'd17, 32'h00000AB0);
    issue(enc_i(12'h004, 5'd6, 3'd1, 5'd17, OPC_OPIMM));       // SLLI
    push_commit(5'd18, 32'h0);
    issue(enc_i(12'h001, 5'd9, 3'd0, 5'd18, OPC_OPIMM));       // ADDI x18,x9,1 (wraps)

    dut.regfile[1] <= 32'h00000040; #1;
    push_commit(5'd2, 32'h0);
    issue(enc_i(12'd0, 5'd1, 3'd4, 5'd2, OPC_LOAD));           // LBU x2,0(x1): aliases word 0
    chk("alias_addr", bus.mem_addr, 32'h00000040);
    push_commit(5'd20, 32'h000000FF);
    issue(enc_i(12'hFFF, 5'd0, 3'd4, 5'd20, OPC_LOAD));        // LBU x20,-1(x0)
    chk("wrap_addr", bus.mem_addr, 32'hFFFFFFFF);

    issue(32'h0000007F);
    chk("nop_cv", 32'(bus.commit_valid), 32'h0);
    chk("nop_pc", bus.pc, exp_pc);
    chk("nop_hold_rd", 32'(bus.commit_rd), 32'd20);

`ifdef SODOR5_WIDE_MEM_EN
    push_commit(5'd21, 32'hFFFFAB55);
    issue(enc_i(12'd0, 5'd5, 3'd1, 5'd21, OPC_LOAD));          // LH x21,0(x5)
`else
    issue(enc_i(12'd0, 5'd5, 3'd1, 5'd21, OPC_LOAD));          // LH is a NOP here
    chk("lh_nop_cv", 32'(bus.commit_valid), 32'h0);
`endif

    reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    bus.instr = enc_s(12'd0, 5'd6, 5'd5, 3'd0);                // SB ignored under reset
    @(posedge clk); #2;
    reset_n = 1'b1;
    exp_pc = 32'h0;
    chk("mid_pc", bus.pc, 32'h0);
    chk("mid_dmem5", dut.dmem[5], 32'h5555AB55);
    chk("mid_x8", dut.regfile[8], 32'hF8000000);
    push_commit(5'd22, 32'h5);
    issue(enc_i(12'd5, 5'd0, 3'd0, 5'd22, OPC_OPIMM));         // ADDI x22,x0,5
    chk("mid_pc_adv", bus.pc, 32'h4);

    @(negedge clk); #1;
    chk("commit_q_drained", 32'(cq.size()), 32'h0);
    chk("store_q_drained", 32'(sq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
